signed_result_bcd_decoder: RTL
==============================

Name: signed_result_bcd_decoder

Overview:
Takes a two's-complement result word from the adder/subtractor datapath and converts it to sign plus packed BCD digits for display.
- Sequential block: one iterative shift-add-3 (double-dabble) step per clock.
- Valid/ready handshakes on both sides.
- Sits between the arithmetic unit and the display driver.

Parameters:
WIDTH, 5, input width in bits (two's complement); legal range 2..16
DIGITS, 2, BCD digits produced; elaboration must fail unless 2^(WIDTH-1) <= 10^DIGITS - 1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word; high exactly when in IDLE
in_data  input  WIDTH  two's-complement value to convert
out_valid  output  1  out_sign/out_bcd hold a completed result
out_ready  input  1  consumer accepts result
out_sign  output  1  1 = value was negative
out_bcd  output  4*DIGITS  packed BCD magnitude, digit 0 in [3:0]

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, out_valid 0, out_sign 0, out_bcd 0, iteration count 0, internal shift registers 0. in_ready reads 1. Inputs are ignored while rst_n is low.
- States: IDLE, CONV, HOLD.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, capture the input and go to CONV. Captured values:
    - sign = in_data[WIDTH-1]
    - magnitude = absolute value, computed as a WIDTH-bit unsigned value. -2^(WIDTH-1) gives 2^(WIDTH-1), with no overflow.
    - BCD accumulator cleared; counter = 0.
- CONV: each edge performs one double-dabble step.
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, magnitude} shifts left by 1.
  - Counter increments. After the WIDTH-th step go to HOLD.
  - in_ready = 0. in_valid is ignored.
- HOLD:
  - out_valid = 1; out_sign and out_bcd are stable registered values.
  - On an edge with out_ready = 1, go to IDLE and drop out_valid.
  - Data stays held indefinitely while out_ready = 0.
- Latency: capture edge E0, conversion edges E1..E_WIDTH. out_valid is high immediately after E_WIDTH, i.e. WIDTH cycles after capture (5 by default).
- Throughput: one word per WIDTH+2 cycles minimum. There is no same-cycle turnaround from HOLD into a new capture.
- Zero is never negative: input 0 gives out_sign 0.
- out_sign and out_bcd update only on the transition into HOLD. Between results they keep the previous result (0 after reset).
- Reset mid-CONV or mid-HOLD: immediate return to IDLE with all outputs cleared; no partial result is emitted.

Optional Feature:
Macro SEG7_EN.
- Defined: adds these outputs:
  - out_seg, output, 7*DIGITS bits: per-digit active-high segments {g,f,e,d,c,b,a}, digit 0 in [6:0].
  - out_seg_minus, output, 1 bit: equals out_sign; drives a minus sign on segment g.
- Encodings: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Nibbles >9 give 0000000.
- out_seg and out_seg_minus are registered with out_bcd and reset to 0.
- Not defined: these ports and their logic are absent; everything else is identical.

Test Plan:
- Reset, then in_data=5'b01111 with in_valid=1 for one cycle -> in_ready low for 6 cycles; out_valid high 5 cycles after capture; out_sign=0, out_bcd=8'h15.
- in_data=5'b10000 -> out_sign=1, out_bcd=8'h16 (most-negative case, no overflow).
- in_data=5'b11111, then 5'b00000 -> {1,8'h01}, then {0,8'h00} (zero not negative).
- in_data=5'b11001 (-7), out_ready held 0 for 4 cycles after out_valid, in_valid=1 with 5'b00011 throughout -> result {1,8'h07} held stable and 5'b00011 not captured while out_ready=0. After out_ready=1: IDLE, then 5'b00011 is captured (in_valid still high).
- Assert rst_n=0 at the 3rd CONV cycle of 5'b01010 -> outputs go 0 asynchronously, in_ready=1. After release, converting 5'b00101 gives {0,8'h05}.
- With SEG7_EN, in_data=5'b10110 (-10) -> out_bcd=8'h10, out_seg=14'b0000110_0111111, out_seg_minus=1.

Source files
------------

// File: rtl/signed_result_bcd_decoder.sv
// Two's-complement word to sign + packed BCD, one double-dabble step per clock.
// Optional SEG7_EN adds registered seven-segment outputs alongside out_bcd.
module signed_result_bcd_decoder #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [4*DIGITS-1:0]   out_bcd
`ifdef SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   out_seg,
  output logic                  out_seg_minus
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // The largest magnitude, 2^(WIDTH-1), must fit in the BCD digits.
  generate
    if (WIDTH < 2 || WIDTH > 16) begin : gBadWidth
      $error("signed_result_bcd_decoder: WIDTH must be in 2..16");
    end
    if ((64'd1 << (WIDTH - 1)) > (pow10(DIGITS) - 64'd1)) begin : gBadDigits
      $error("signed_result_bcd_decoder: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [WIDTH-1:0] mag_q;
  logic [BW-1:0]   bcd_q;
  logic            sign_q;
  logic            outValid_q;
  logic            outSign_q;
  logic [BW-1:0]   outBcd_q;

  logic [WIDTH-1:0] absIn;
  logic [BW-1:0]    bcdAdj;
  logic [BW-1:0]    bcd_d;
  logic [WIDTH-1:0] mag_d;
  logic             unusedMsb;

  // Magnitude stays WIDTH bits: the most negative input maps onto 2^(WIDTH-1).
  assign absIn = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;

  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcdAdj[BW-2:0], mag_q[WIDTH-1]};
    mag_d = {mag_q[WIDTH-2:0], 1'b0};
  end

  // The top bit falls off the shift; it can only be set on a range violation.
  assign unusedMsb = bcdAdj[BW-1];

`ifdef SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  logic [7*DIGITS-1:0] seg_d;
  logic [7*DIGITS-1:0] outSeg_q;
  logic                outSegMinus_q;

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < DIGITS; i++) seg_d[7*i +: 7] = seg7(bcd_d[4*i +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outSeg_q      <= '0;
      outSegMinus_q <= 1'b0;
    end else if (state_q == CONV && count_q == CW'(WIDTH - 1)) begin
      outSeg_q      <= seg_d;
      outSegMinus_q <= sign_q;
    end
  end

  assign out_seg       = outSeg_q;
  assign out_seg_minus = outSegMinus_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      outValid_q <= 1'b0;
      outSign_q  <= 1'b0;
      outBcd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_data[WIDTH-1];
            mag_q   <= absIn;
            bcd_q   <= '0;
            count_q <= '0;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= bcd_d;
          mag_q   <= mag_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q    <= HOLD;
            outValid_q <= 1'b1;
            outSign_q  <= sign_q;
            outBcd_q   <= bcd_d;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign out_sign  = outSign_q;
  assign out_bcd   = outBcd_q;

endmodule
